// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : ALU opcodes, write-back target encoding and drain helpers
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    localparam logic [1:0] TGT_GPR = 2'b00;
    localparam logic [1:0] TGT_LO  = 2'b01;
    localparam logic [1:0] TGT_HI  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SINGLE = 2'd1,
        ST_LO     = 2'd2,
        ST_HI     = 2'd3
    } drain_state_t;

    typedef enum logic [1:0] {
        CLS_DROP   = 2'd0,
        CLS_SINGLE = 2'd1,
        CLS_DOUBLE = 2'd2
    } op_class_t;

    function automatic op_class_t classify_op(input logic [4:0] op);
        op_class_t cls;
        cls = CLS_DROP;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
            OP_ROR, OP_ROL, OP_NEG, OP_NOT: cls = CLS_SINGLE;
            OP_MUL, OP_DIV:                 cls = CLS_DOUBLE;
            default:                        cls = CLS_DROP;
        endcase
        return cls;
    endfunction

    // State the drain machine enters when an entry becomes the head
    function automatic drain_state_t head_state(input logic two_beat);
        return two_beat ? ST_LO : ST_SINGLE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Power-of-two FIFO with head and next-after-head peek ports
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_head,
    output logic [WIDTH-1:0]         o_next,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full
);
    localparam int                   c_ptr_w   = $clog2(DEPTH);
    localparam int                   c_cnt_w   = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0]   c_depth   = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0]   c_cnt_one = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0]   c_ptr_one = c_ptr_w'(1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [c_ptr_w-1:0] w_rd_ptr_nxt;

    assign w_rd_ptr_nxt = r_rd_ptr + c_ptr_one;

    // Storage carries no reset; validity is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (i_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_next  = r_mem[w_rd_ptr_nxt];
    assign o_count = r_count;
    assign o_full  = (r_count == c_depth);

endmodule
`default_nettype wire

// File: rtl/alu_writeback_queue.sv
`default_nettype none
// ============================================================================
//  Module      : alu_writeback_queue
//  Description : Queues ALU results and drains them as GPR or LO/HI write beats
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_writeback_queue
    import alu_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int REG_ADDR_W = 4
) (
    input  logic                     Clock,
    input  logic                     Clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_Control,
    input  logic [REG_ADDR_W-1:0]    in_dest,
    input  logic [63:0]              in_result,
    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [1:0]               wb_target,
    output logic [REG_ADDR_W-1:0]    wb_addr,
    output logic [31:0]              wb_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int                 c_cnt_w   = $clog2(DEPTH) + 1;
    localparam int                 c_entry_w = 1 + REG_ADDR_W + 64;
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    op_class_t              w_class;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_hs;
    logic                   w_full;
    logic [c_entry_w-1:0]   w_in_entry;
    logic [c_entry_w-1:0]   w_head;
    logic [c_entry_w-1:0]   w_next;
    logic [REG_ADDR_W-1:0]  w_head_dest;
    logic [63:0]            w_head_res;
    logic                   w_next_two;
    logic                   w_in_two;
    logic                   w_unused_bits;
    logic                   r_active;
    drain_state_t           r_state;
    drain_state_t           w_state_nxt;

    assign w_class    = classify_op(in_Control);
    assign w_in_two   = (w_class == CLS_DOUBLE);
    assign w_push     = in_valid && in_ready && (w_class != CLS_DROP);
    assign w_in_entry = {w_in_two, in_dest, in_result};

    // Ready opens on the first clock edge after reset release
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
        end
    end

    assign in_ready = r_active && !w_full;

    sync_fifo #(
        .WIDTH (c_entry_w),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (Clock),
        .rst_n   (Clear),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_in_entry),
        .o_head  (w_head),
        .o_next  (w_next),
        .o_count (count),
        .o_full  (w_full)
    );

    assign w_head_dest   = w_head[64 +: REG_ADDR_W];
    assign w_head_res    = w_head[63:0];
    assign w_next_two    = w_next[c_entry_w-1];
    assign w_unused_bits = ^{w_head[c_entry_w-1], w_next[c_entry_w-2:0]};

    assign wb_valid = (r_state != ST_IDLE);
    assign w_hs     = wb_valid && wb_ready;
    assign w_pop    = w_hs && ((r_state == ST_SINGLE) || (r_state == ST_HI));

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // After a pop the new head is the next stored entry, or the entry
    // written on this same edge when the queue would otherwise run dry.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_push) begin
                    w_state_nxt = head_state(w_in_two);
                end
            end
            ST_LO: begin
                if (w_hs) begin
                    w_state_nxt = ST_HI;
                end
            end
            ST_SINGLE, ST_HI: begin
                if (w_pop) begin
                    if (count > c_cnt_one) begin
                        w_state_nxt = head_state(w_next_two);
                    end else if (w_push) begin
                        w_state_nxt = head_state(w_in_two);
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        wb_target = TGT_GPR;
        wb_addr   = '0;
        wb_data   = '0;
        case (r_state)
            ST_SINGLE: begin
                wb_target = TGT_GPR;
                wb_addr   = w_head_dest;
                wb_data   = w_head_res[31:0];
            end
            ST_LO: begin
                wb_target = TGT_LO;
                wb_data   = w_head_res[31:0];
            end
            ST_HI: begin
                wb_target = TGT_HI;
                wb_data   = w_head_res[63:32];
            end
            default: begin
                wb_target = TGT_GPR;
            end
        endcase
    end

endmodule
`default_nettype wire
